// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction fetch stage. It keeps the PC, issues one instruction-memory
// request at a time, and presents one registered instruction per fetch to
// decode. A one-entry skid buffer holds a returned word while decode is
// stalled, so no word is ever lost. A taken branch flushes the output register
// and the skid buffer. If a request is still in flight when the branch
// arrives, its response is dropped when it returns.
//
// Ports
//   clk, rst_n        clock (rising edge) / asynchronous active-low reset
//   imem_req          request valid; address held until accepted
//   imem_addr         fetch address (= PC, word aligned)
//   imem_ready        memory accepts the request this cycle
//   imem_rvalid       read data valid, one pulse per accepted request
//   imem_rdata        returned instruction word
//   branch_taken      redirect pulse from execute
//   branch_target     redirect address (bits [1:0] ignored)
//   stall             decode cannot accept; output register holds
//   if_valid          output instruction valid
//   if_pc             PC of if_instr
//   if_instr          instruction, NOP (32'h13) whenever if_valid = 0
//   if_opcode         if_instr[6:0], feeds the control decoder directly
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            stall,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr,
  output logic [6:0]      if_opcode
);

  localparam logic [31:0]     NOP     = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_WAIT  = 1'b1
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic            kill;

  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_instr;

  logic            skid_valid;
  logic [XLEN-1:0] skid_pc;
  logic [31:0]     skid_instr;

  logic [XLEN-1:0] branch_pc;
  logic            resp_fire;
  logic            resp_take;
  logic            consume;

  assign branch_pc = {branch_target[XLEN-1:2], 2'b00};

  // The request is gated by rst_n so it stays low during reset and rises as
  // soon as reset is released. It is also suppressed while a redirect is
  // present, so a request can never be accepted in the same cycle as a
  // branch. Only a request already in flight (S_WAIT) can therefore need
  // killing.
  assign imem_req  = rst_n && (state == S_FETCH) && !skid_valid && !branch_taken;
  assign imem_addr = {pc[XLEN-1:2], 2'b00};

  // A response only counts in S_WAIT. A stray rvalid in S_FETCH, for
  // example after a reset in mid-flight, is ignored.
  assign resp_fire = (state == S_WAIT) && imem_rvalid;
  assign resp_take = resp_fire && !kill && !branch_taken;
  assign consume   = out_valid && !stall;

  assign if_valid  = out_valid;
  assign if_pc     = out_pc;
  assign if_instr  = out_instr;
  assign if_opcode = out_instr[6:0];

  // NOTE: sequential state uses non-blocking assignments only. Every
  // register then samples values from before the edge, whatever order the
  // statements below are written in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      kill       <= 1'b0;
      out_valid  <= 1'b0;
      out_pc     <= RESET_PC;
      out_instr  <= NOP;
      skid_valid <= 1'b0;
    end else begin
      unique case (state)
        S_FETCH: if (imem_req && imem_ready) state <= S_WAIT;
        S_WAIT:  if (imem_rvalid)            state <= S_FETCH;
        default:                             state <= S_FETCH;
      endcase

      // The response (killed or not) always clears kill. A redirect while
      // waiting marks the outstanding response as stale, including a second
      // redirect during an already-killed wait.
      if (resp_fire) begin
        kill <= 1'b0;
      end else if (branch_taken && (state == S_WAIT)) begin
        kill <= 1'b1;
      end

      if (branch_taken) begin
        pc <= branch_pc;
      end else if (resp_take) begin
        pc <= pc + PC_STEP;
      end

      // The output register and the skid buffer are ordered so that the skid
      // word always leaves before a newer response.
      if (branch_taken) begin
        out_valid  <= 1'b0;
        out_instr  <= NOP;
        skid_valid <= 1'b0;
      end else if (consume) begin
        if (skid_valid) begin
          out_pc     <= skid_pc;
          out_instr  <= skid_instr;
          skid_valid <= resp_take;
        end else if (resp_take) begin
          out_pc    <= pc;
          out_instr <= imem_rdata;
        end else begin
          out_valid <= 1'b0;
          out_instr <= NOP;
        end
      end else if (resp_take) begin
        if (!out_valid) begin
          out_valid <= 1'b1;
          out_pc    <= pc;
          out_instr <= imem_rdata;
        end else begin
          skid_valid <= 1'b1;
        end
      end
    end
  end

  // NOTE: the skid payload has no reset. skid_valid qualifies it, so the
  // value it holds while empty never matters. Loading it on every accepted
  // response covers both ways the skid can fill.
  always_ff @(posedge clk) begin
    if (resp_take) begin
      skid_pc    <= pc;
      skid_instr <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed bench for instr_fetch_unit. The memory side is driven by hand,
// cycle by cycle. Inputs change on the falling edge, and outputs are checked
// 1 ns later, well away from the rising edge. Returned words are tagged with
// their address: word(a) = 32'hA000_0033 | (a << 7), opcode 7'h33.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic            clk;
  logic            rst_n;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic            stall;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [31:0]     if_instr;
  logic [6:0]      if_opcode;

  int vectors    = 0;
  int miscompares = 0;

  instr_fetch_unit #(
    .XLEN     (XLEN),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .stall         (stall),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_instr      (if_instr),
    .if_opcode     (if_opcode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'hA000_0033 | (a << 7);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Output-register checks. The PC is only compared while valid.
  task automatic check_out(input string tag, input logic v, input logic [31:0] pc,
                           input logic [31:0] instr);
    check({tag, ".if_valid"}, 32'(if_valid), 32'(v));
    if (v) check({tag, ".if_pc"}, if_pc, pc);
    check({tag, ".if_instr"}, if_instr, instr);
    check({tag, ".if_opcode"}, 32'(if_opcode), 32'(instr[6:0]));
  endtask

  task automatic check_req(input string tag, input logic req, input logic [31:0] addr);
    check({tag, ".imem_req"}, 32'(imem_req), 32'(req));
    if (req) check({tag, ".imem_addr"}, imem_addr, addr);
  endtask

  // Advance to the next falling edge. One-cycle pulses are cleared here.
  task automatic next_cycle();
    @(negedge clk);
    imem_rvalid  = 1'b0;
    imem_rdata   = 32'hDEAD_BEEF;
    branch_taken = 1'b0;
  endtask

  task automatic respond(input logic [31:0] a);
    imem_rvalid = 1'b1;
    imem_rdata  = word(a);
  endtask

  initial begin
    rst_n         = 1'b0;
    imem_ready    = 1'b1;
    imem_rvalid   = 1'b0;
    imem_rdata    = 32'h0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    stall         = 1'b0;

    // ---- reset values ----
    next_cycle(); #1;
    check_req("rst", 1'b0, 32'h0);
    check_out("rst", 1'b0, 32'h0, NOP);
    check("rst.if_pc", if_pc, 32'h0);
    next_cycle();

    // ---- free run, 1-cycle memory ----
    rst_n = 1'b1; #1;                                  // C0
    check_req("c0", 1'b1, 32'h0);
    next_cycle(); respond(32'h0); #1;                  // C1
    check_req("c1", 1'b0, 32'h0);
    check_out("c1", 1'b0, 32'h0, NOP);
    next_cycle(); #1;                                  // C2
    check_out("c2", 1'b1, 32'h0, word(32'h0));
    check_req("c2", 1'b1, 32'h4);
    next_cycle(); respond(32'h4); #1;                  // C3
    check_out("c3", 1'b0, 32'h0, NOP);
    next_cycle(); #1;                                  // C4
    check_out("c4", 1'b1, 32'h4, word(32'h4));
    check_req("c4", 1'b1, 32'h8);
    next_cycle(); respond(32'h8); #1;                  // C5
    check_out("c5", 1'b0, 32'h0, NOP);

    // ---- stall for 5 cycles while the next word returns ----
    next_cycle(); stall = 1'b1; #1;                    // C6
    check_out("c6", 1'b1, 32'h8, word(32'h8));
    check_req("c6", 1'b1, 32'hC);
    next_cycle(); respond(32'hC); #1;                  // C7
    check_out("c7", 1'b1, 32'h8, word(32'h8));
    check_req("c7", 1'b0, 32'h0);
    for (int i = 8; i <= 10; i++) begin                // C8..C10, skid full
      next_cycle(); #1;
      check_req("skid_full", 1'b0, 32'h0);
      check_out("skid_hold", 1'b1, 32'h8, word(32'h8));
    end
    next_cycle(); stall = 1'b0; #1;                    // C11
    check_out("c11", 1'b1, 32'h8, word(32'h8));
    check_req("c11", 1'b0, 32'h0);
    next_cycle(); #1;                                  // C12, skid word emerges
    check_out("c12", 1'b1, 32'hC, word(32'hC));
    check_req("c12", 1'b1, 32'h10);

    // ---- redirect to 0x100 while waiting ----
    next_cycle(); branch_taken = 1'b1; branch_target = 32'h100; #1;  // C13
    check_out("c13", 1'b0, 32'h0, NOP);
    check_req("c13", 1'b0, 32'h0);
    next_cycle(); respond(32'h10); #1;                 // C14, killed response
    check_req("c14", 1'b0, 32'h0);
    next_cycle(); #1;                                  // C15
    check_out("c15", 1'b0, 32'h0, NOP);
    check_req("c15", 1'b1, 32'h100);
    next_cycle(); respond(32'h100); #1;                // C16
    check_out("c16", 1'b0, 32'h0, NOP);
    next_cycle(); stall = 1'b1; #1;                    // C17
    check_out("c17", 1'b1, 32'h100, word(32'h100));
    check_req("c17", 1'b1, 32'h104);

    // ---- redirect with stall high, skid full, stray rvalid ----
    next_cycle(); respond(32'h104); #1;                // C18, fills skid
    check_out("c18", 1'b1, 32'h100, word(32'h100));
    next_cycle();                                      // C19
    branch_taken = 1'b1; branch_target = 32'h200;
    imem_rvalid = 1'b1; imem_rdata = 32'h1234_5677; #1;
    check_req("c19", 1'b0, 32'h0);
    check_out("c19", 1'b1, 32'h100, word(32'h100));
    next_cycle(); #1;                                  // C20, flushed
    check_out("c20", 1'b0, 32'h0, NOP);
    check_req("c20", 1'b1, 32'h200);
    next_cycle(); stall = 1'b0; respond(32'h200); #1;  // C21
    check_out("c21", 1'b0, 32'h0, NOP);

    // ---- memory not ready for 3 cycles ----
    next_cycle(); imem_ready = 1'b0; #1;               // C22
    check_out("c22", 1'b1, 32'h200, word(32'h200));
    check_req("c22", 1'b1, 32'h204);
    next_cycle(); #1;                                  // C23
    check_req("c23", 1'b1, 32'h204);
    next_cycle(); #1;                                  // C24
    check_req("c24", 1'b1, 32'h204);
    next_cycle(); imem_ready = 1'b1; #1;               // C25
    check_req("c25", 1'b1, 32'h204);
    check_out("c25", 1'b0, 32'h0, NOP);
    next_cycle(); respond(32'h204); #1;                // C26
    check_req("c26", 1'b0, 32'h0);

    // ---- redirect to unaligned target 0x103 from FETCH ----
    next_cycle(); branch_taken = 1'b1; branch_target = 32'h103; #1;  // C27
    check_out("c27", 1'b1, 32'h204, word(32'h204));
    check("c27.imem_addr", imem_addr, 32'h208);
    check_req("c27", 1'b0, 32'h0);
    next_cycle(); #1;                                  // C28
    check_out("c28", 1'b0, 32'h0, NOP);
    check_req("c28", 1'b1, 32'h100);
    next_cycle(); respond(32'h100); #1;                // C29
    next_cycle(); #1;                                  // C30
    check_out("c30", 1'b1, 32'h100, word(32'h100));
    check_req("c30", 1'b1, 32'h104);

    // ---- two redirects during one wait, kill stays set ----
    next_cycle(); branch_taken = 1'b1; branch_target = 32'h300; #1;  // C31
    check_req("c31", 1'b0, 32'h0);
    next_cycle(); branch_taken = 1'b1; branch_target = 32'h400; #1;  // C32
    check_req("c32", 1'b0, 32'h0);
    next_cycle(); respond(32'h104); #1;                // C33, killed
    check_out("c33", 1'b0, 32'h0, NOP);
    next_cycle(); #1;                                  // C34
    check_out("c34", 1'b0, 32'h0, NOP);
    check_req("c34", 1'b1, 32'h400);
    next_cycle(); respond(32'h400); #1;                // C35
    next_cycle(); stall = 1'b1; #1;                    // C36
    check_out("c36", 1'b1, 32'h400, word(32'h400));
    check_req("c36", 1'b1, 32'h404);

    // ---- asynchronous reset in the middle of a wait ----
    next_cycle(); #1;                                  // C37
    check_out("c37", 1'b1, 32'h400, word(32'h400));
    #1 rst_n = 1'b0; #1;
    check_out("arst", 1'b0, 32'h0, NOP);
    check("arst.if_pc", if_pc, 32'h0);
    check_req("arst", 1'b0, 32'h0);
    next_cycle();                                      // C38, stray rvalid
    stall = 1'b0; rst_n = 1'b1; respond(32'h404); #1;
    check_req("c38", 1'b1, 32'h0);
    check_out("c38", 1'b0, 32'h0, NOP);
    next_cycle(); respond(32'h0); #1;                  // C39
    check_out("c39", 1'b0, 32'h0, NOP);
    check_req("c39", 1'b0, 32'h0);
    next_cycle(); #1;                                  // C40
    check_out("c40", 1'b1, 32'h0, word(32'h0));
    check_req("c40", 1'b1, 32'h4);

    next_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage that drives the instruction-memory port, maintains the PC, and presents one registered instruction per fetch to the decode stage, where `if_opcode` feeds the control decoder directly. It supports one outstanding memory request and a one-entry skid buffer so downstream stalls never lose a returned word. Taken-branch redirects flush in-flight and buffered instructions.

## Interface
- `XLEN`, 32: address/data width.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req` out 1: request valid; address held stable until accepted.
- `imem_addr` out XLEN: fetch address (= PC), word aligned.
- `imem_ready` in 1: request accepted this cycle when high with `imem_req`.
- `imem_rvalid` in 1: read data valid, one pulse per accepted request, arriving at least 1 cycle after acceptance.
- `imem_rdata` in 32: instruction word.
- `branch_taken` in 1: redirect pulse from execute.
- `branch_target` in XLEN: redirect address; bits [1:0] ignored (forced 00).
- `stall` in 1: decode cannot accept; holds the output register.
- `if_valid` out 1: output instruction valid.
- `if_pc` out XLEN: PC of `if_instr`.
- `if_instr` out 32: instruction; forced to 32'h0000_0013 (NOP) whenever `if_valid`=0.
- `if_opcode` out 7: `if_instr[6:0]`.

## Operation
- States: FETCH, WAIT.
- FETCH: `imem_req` = 1 iff skid empty and `branch_taken`=0; on `imem_req & imem_ready` go to WAIT. Otherwise stay.
- WAIT: `imem_req`=0; on `imem_rvalid` go to FETCH (next request the following cycle).
- Consume = `if_valid & !stall`.
- Response accept (rvalid, not killed): PC <= PC+4 (mod 2^XLEN). Word goes to output reg if output empty or consumed this cycle and skid empty; otherwise to skid.
- On consume: output <= skid if skid valid (skid then empties; a same-cycle response goes into skid); else <= accepted response; else `if_valid` <= 0.
- Skid cannot overflow: requests issue only when skid empty and one request max in flight.
- Redirect (`branch_taken`=1), priority over everything including `stall`: PC <= target; output and skid invalidated next cycle; a response arriving the same cycle is discarded; if a request is in flight, or is accepted that cycle, set `kill`.
- `kill`: next `imem_rvalid` is discarded and clears `kill`; PC unaffected. Redirect during a killed WAIT leaves `kill` set and updates PC.
- `stall` with skid full: no new request; contents held.

## Timing
- Reset (async assert): state FETCH, PC=`RESET_PC`, `kill`=0, skid empty, `if_valid`=0, `if_pc`=`RESET_PC`, `if_instr`=32'h0000_0013, `imem_req`=0 while `rst_n`=0.
- First `imem_req` is in the first cycle after reset deassertion, with `imem_addr`=`RESET_PC`.
- Latency: request accepted at cycle N, `rvalid` at N+k; `if_valid` is high at N+k+1.
- Throughput with k=1, no stalls: one instruction every 2 cycles.
- Redirect at cycle R: `if_valid`=0 at R+1; request to target no earlier than R+1, and only after any killed response has returned.
- Reset asserted mid-WAIT: all state cleared immediately; a later stray `rvalid` while in FETCH is ignored.

## Test plan
- Reset then free-run, 1-cycle memory returning addr-tagged words: `if_pc` = 0,4,8,… with matching `if_instr`; `if_valid` high every other cycle.
- `stall` held 5 cycles while a response returns: word lands in skid, no new `imem_req`; on release the two words emerge in order with PCs 0x8 and 0xC and none lost.
- `branch_taken` with target 0x100 in WAIT: old response discarded, next `imem_addr`=0x100, first valid `if_pc`=0x100.
- Redirect on the same cycle as `rvalid`, with `stall` high and skid full: output and skid flushed, `if_valid`=0 next cycle, `if_instr`=0x13, then fetch from target.
- `imem_ready` low 3 cycles: `imem_addr` stable, exactly one `rvalid` consumed per acceptance; target 0x103 fetches 0x100.
- `rst_n` pulsed low mid-WAIT: outputs return to reset values asynchronously; fetch restarts at `RESET_PC`.
